// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer.
// Decode allocates entries at the tail in program order. The ALU, MUL and cache
// writeback ports mark entries done out of order. The head entry retires one
// per cycle, or raises its stored exception and flushes the whole buffer.
//
// Ports:
//   clock, reset             core clock, asynchronous active-high reset
//   alloc_valid/_dest_reg/_we  allocation request from decode
//   alloc_ready, alloc_rob_id  entry available / tail index (combinational)
//   {alu,mul,cache}_wb_*       writeback strobe, entry id, data, exception record
//   commit_valid/_we/_dest_reg/_data  registered one-cycle retire pulse
//   xcpt_info, flush           registered exception record and pipeline flush

package reorder_buffer_pkg;

  typedef enum logic [3:0] {
    XCPT_NONE            = 4'd0,
    XCPT_ILLEGAL_INSTR   = 4'd1,
    XCPT_ADDR_MISALIGNED = 4'd2,
    XCPT_OVERFLOW        = 4'd3,
    XCPT_PAGE_FAULT      = 4'd4
  } xcpt_type_t;

  typedef struct packed {
    logic        valid;
    xcpt_type_t  xcpt_type;
    logic [31:0] addr_val;
    logic [31:0] pc;
  } reorder_buffer_xcpt_info_t;

endpackage

module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_ENTRIES = 8,
  parameter int ROB_IDX_W   = 3,
  parameter int REG_W       = 5,
  parameter int DATA_W      = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      alloc_valid,
  input  logic [REG_W-1:0]          alloc_dest_reg,
  input  logic                      alloc_we,
  output logic                      alloc_ready,
  output logic [ROB_IDX_W-1:0]      alloc_rob_id,
  input  logic                      alu_wb_valid,
  input  logic [ROB_IDX_W-1:0]      alu_wb_rob_id,
  input  logic [DATA_W-1:0]         alu_wb_data,
  input  reorder_buffer_xcpt_info_t alu_rob_xcpt_info,
  input  logic                      mul_wb_valid,
  input  logic [ROB_IDX_W-1:0]      mul_wb_rob_id,
  input  logic [DATA_W-1:0]         mul_wb_data,
  input  reorder_buffer_xcpt_info_t mul_rob_xcpt_info,
  input  logic                      cache_wb_valid,
  input  logic [ROB_IDX_W-1:0]      cache_wb_rob_id,
  input  logic [DATA_W-1:0]         cache_wb_data,
  input  reorder_buffer_xcpt_info_t cache_rob_xcpt_info,
  output logic                      commit_valid,
  output logic                      commit_we,
  output logic [REG_W-1:0]          commit_dest_reg,
  output logic [DATA_W-1:0]         commit_data,
  output reorder_buffer_xcpt_info_t xcpt_info,
  output logic                      flush
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t                    state_q;
  logic [ROB_IDX_W-1:0]      head_q, head_d;
  logic [ROB_IDX_W-1:0]      tail_q, tail_d;
  logic [ROB_IDX_W:0]        count_q, count_d;

  logic                      busy_q [ROB_ENTRIES];
  logic                      done_q [ROB_ENTRIES];
  logic                      we_q   [ROB_ENTRIES];
  logic [REG_W-1:0]          dest_q [ROB_ENTRIES];
  logic [DATA_W-1:0]         data_q [ROB_ENTRIES];
  reorder_buffer_xcpt_info_t xcpt_q [ROB_ENTRIES];

  logic                      commitValid_q, commitWe_q, flush_q;
  logic [REG_W-1:0]          commitDest_q;
  logic [DATA_W-1:0]         commitData_q;
  reorder_buffer_xcpt_info_t xcptInfo_q;

  logic                      allocFire, headReady, commitFire, xcptFire;

  // Writeback ports gathered so a loop can apply them; later index wins,
  // giving cache > mul > alu on a (forbidden) same-id collision.
  logic                      wbValid [3];
  logic [ROB_IDX_W-1:0]      wbId    [3];
  logic [DATA_W-1:0]         wbData  [3];
  reorder_buffer_xcpt_info_t wbXcpt  [3];

  assign wbValid[0] = alu_wb_valid;
  assign wbValid[1] = mul_wb_valid;
  assign wbValid[2] = cache_wb_valid;
  assign wbId[0]    = alu_wb_rob_id;
  assign wbId[1]    = mul_wb_rob_id;
  assign wbId[2]    = cache_wb_rob_id;
  assign wbData[0]  = alu_wb_data;
  assign wbData[1]  = mul_wb_data;
  assign wbData[2]  = cache_wb_data;
  assign wbXcpt[0]  = alu_rob_xcpt_info;
  assign wbXcpt[1]  = mul_rob_xcpt_info;
  assign wbXcpt[2]  = cache_rob_xcpt_info;

  // A full buffer refuses allocation even when the head retires this cycle.
  assign alloc_ready  = (count_q < (ROB_IDX_W+1)'(ROB_ENTRIES)) && (state_q == RUN);
  assign alloc_rob_id = tail_q;
  assign allocFire    = alloc_valid && alloc_ready;

  assign headReady  = (state_q == RUN) && busy_q[head_q] && done_q[head_q];
  assign commitFire = headReady && !xcpt_q[head_q].valid;
  assign xcptFire   = headReady &&  xcpt_q[head_q].valid;

  assign head_d  = head_q + ROB_IDX_W'(commitFire);
  assign tail_d  = tail_q + ROB_IDX_W'(allocFire);
  assign count_d = count_q + (ROB_IDX_W+1)'(allocFire) - (ROB_IDX_W+1)'(commitFire);

  assign commit_valid    = commitValid_q;
  assign commit_we       = commitWe_q;
  assign commit_dest_reg = commitDest_q;
  assign commit_data     = commitData_q;
  assign xcpt_info       = xcptInfo_q;
  assign flush           = flush_q;

  // Entry storage. The FLUSH cycle wipes every entry, which also discards an
  // allocation accepted in the exception-detect cycle; writebacks arriving
  // during FLUSH are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        busy_q[i] <= 1'b0;
        done_q[i] <= 1'b0;
        we_q[i]   <= 1'b0;
        dest_q[i] <= '0;
        data_q[i] <= '0;
        xcpt_q[i] <= '0;
      end
    end else if (state_q == FLUSH) begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        busy_q[i] <= 1'b0;
        done_q[i] <= 1'b0;
        xcpt_q[i] <= '0;
      end
    end else begin
      if (allocFire) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        xcpt_q[tail_q] <= '0;
        dest_q[tail_q] <= alloc_dest_reg;
        we_q[tail_q]   <= alloc_we;
      end
      if (commitFire) begin
        busy_q[head_q] <= 1'b0;
      end
      for (int p = 0; p < 3; p++) begin
        if (wbValid[p] && busy_q[wbId[p]]) begin
          done_q[wbId[p]] <= 1'b1;
          data_q[wbId[p]] <= wbData[p];
          if (wbXcpt[p].valid) begin
            xcpt_q[wbId[p]] <= wbXcpt[p];
          end
        end
      end
    end
  end

  // Retirement FSM with pointers and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commitValid_q <= 1'b0;
      commitWe_q    <= 1'b0;
      commitDest_q  <= '0;
      commitData_q  <= '0;
      xcptInfo_q    <= '0;
      flush_q       <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          head_q        <= head_d;
          tail_q        <= tail_d;
          count_q       <= count_d;
          commitValid_q <= commitFire;
          if (commitFire) begin
            commitWe_q   <= we_q[head_q];
            commitDest_q <= dest_q[head_q];
            commitData_q <= data_q[head_q];
          end
          if (xcptFire) begin
            xcptInfo_q <= xcpt_q[head_q];
            flush_q    <= 1'b1;
            state_q    <= FLUSH;
          end
        end
        FLUSH: begin
          head_q        <= '0;
          tail_q        <= '0;
          count_q       <= '0;
          commitValid_q <= 1'b0;
          xcptInfo_q    <= '0;
          flush_q       <= 1'b0;
          state_q       <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Two ports completing the same entry in one cycle is a protocol violation.
  aluMulSameId: assert property (@(posedge clock) disable iff (reset)
    !(alu_wb_valid && mul_wb_valid && (alu_wb_rob_id == mul_wb_rob_id)));
  aluCacheSameId: assert property (@(posedge clock) disable iff (reset)
    !(alu_wb_valid && cache_wb_valid && (alu_wb_rob_id == cache_wb_rob_id)));
  mulCacheSameId: assert property (@(posedge clock) disable iff (reset)
    !(mul_wb_valid && cache_wb_valid && (mul_wb_rob_id == cache_wb_rob_id)));

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed self-checking bench for reorder_buffer.
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      alloc_valid;
  logic [4:0]                alloc_dest_reg;
  logic                      alloc_we;
  logic                      alloc_ready;
  logic [2:0]                alloc_rob_id;
  logic                      alu_wb_valid, mul_wb_valid, cache_wb_valid;
  logic [2:0]                alu_wb_rob_id, mul_wb_rob_id, cache_wb_rob_id;
  logic [31:0]               alu_wb_data, mul_wb_data, cache_wb_data;
  reorder_buffer_xcpt_info_t alu_rob_xcpt_info, mul_rob_xcpt_info, cache_rob_xcpt_info;
  logic                      commit_valid;
  logic                      commit_we;
  logic [4:0]                commit_dest_reg;
  logic [31:0]               commit_data;
  reorder_buffer_xcpt_info_t xcpt_info;
  logic                      flush;

  int checkCount = 0;
  int errorCount = 0;

  reorder_buffer #(
    .ROB_ENTRIES(8), .ROB_IDX_W(3), .REG_W(5), .DATA_W(32)
  ) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_dest_reg(alloc_dest_reg), .alloc_we(alloc_we),
    .alloc_ready(alloc_ready), .alloc_rob_id(alloc_rob_id),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rob_id(alu_wb_rob_id),
    .alu_wb_data(alu_wb_data), .alu_rob_xcpt_info(alu_rob_xcpt_info),
    .mul_wb_valid(mul_wb_valid), .mul_wb_rob_id(mul_wb_rob_id),
    .mul_wb_data(mul_wb_data), .mul_rob_xcpt_info(mul_rob_xcpt_info),
    .cache_wb_valid(cache_wb_valid), .cache_wb_rob_id(cache_wb_rob_id),
    .cache_wb_data(cache_wb_data), .cache_rob_xcpt_info(cache_rob_xcpt_info),
    .commit_valid(commit_valid), .commit_we(commit_we),
    .commit_dest_reg(commit_dest_reg), .commit_data(commit_data),
    .xcpt_info(xcpt_info), .flush(flush)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearInputs();
    alloc_valid         = 1'b0;
    alloc_dest_reg      = '0;
    alloc_we            = 1'b0;
    alu_wb_valid        = 1'b0;
    mul_wb_valid        = 1'b0;
    cache_wb_valid      = 1'b0;
    alu_wb_rob_id       = '0;
    mul_wb_rob_id       = '0;
    cache_wb_rob_id     = '0;
    alu_wb_data         = '0;
    mul_wb_data         = '0;
    cache_wb_data       = '0;
    alu_rob_xcpt_info   = '0;
    mul_rob_xcpt_info   = '0;
    cache_rob_xcpt_info = '0;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    clearInputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Allocate one entry, first checking the id the bench expects to receive.
  task automatic allocOne(input string tag, input logic [4:0] dest, input logic we,
                          input logic [2:0] expId);
    checkOutput({tag, " alloc_ready"}, 64'(alloc_ready), 64'd1);
    checkOutput({tag, " alloc_rob_id"}, 64'(alloc_rob_id), 64'(expId));
    alloc_valid    = 1'b1;
    alloc_dest_reg = dest;
    alloc_we       = we;
    tick();
    alloc_valid    = 1'b0;
  endtask

  // Drive any combination of the three writeback ports for one cycle.
  task automatic applyStimulus(
    input logic aV, input logic [2:0] aId, input logic [31:0] aD,
    input logic mV, input logic [2:0] mId, input logic [31:0] mD,
    input logic cV, input logic [2:0] cId, input logic [31:0] cD,
    input reorder_buffer_xcpt_info_t mX);
    alu_wb_valid      = aV;  alu_wb_rob_id   = aId; alu_wb_data   = aD;
    mul_wb_valid      = mV;  mul_wb_rob_id   = mId; mul_wb_data   = mD;
    cache_wb_valid    = cV;  cache_wb_rob_id = cId; cache_wb_data = cD;
    mul_rob_xcpt_info = mX;
    tick();
    alu_wb_valid      = 1'b0;
    mul_wb_valid      = 1'b0;
    cache_wb_valid    = 1'b0;
    mul_rob_xcpt_info = '0;
  endtask

  task automatic aluWb(input logic [2:0] id, input logic [31:0] data);
    applyStimulus(1'b1, id, data, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0, '0);
  endtask

  task automatic expectCommit(input string tag, input logic we,
                              input logic [4:0] dest, input logic [31:0] data);
    checkOutput({tag, " commit_valid"}, 64'(commit_valid), 64'd1);
    checkOutput({tag, " commit_we"}, 64'(commit_we), 64'(we));
    checkOutput({tag, " commit_dest_reg"}, 64'(commit_dest_reg), 64'(dest));
    checkOutput({tag, " commit_data"}, 64'(commit_data), 64'(data));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reorder_buffer_xcpt_info_t ovf;
    ovf           = '0;
    ovf.valid     = 1'b1;
    ovf.xcpt_type = XCPT_OVERFLOW;
    ovf.addr_val  = 32'hDEAD_0000;
    ovf.pc        = 32'h0000_0100;

    // Reset state
    resetDut();
    checkOutput("rst commit_valid", 64'(commit_valid), 64'd0);
    checkOutput("rst flush", 64'(flush), 64'd0);
    checkOutput("rst xcpt_valid", 64'(xcpt_info.valid), 64'd0);
    checkOutput("rst alloc_ready", 64'(alloc_ready), 64'd1);
    checkOutput("rst alloc_rob_id", 64'(alloc_rob_id), 64'd0);

    // Test 1: out-of-order writeback, in-order retirement
    allocOne("t1", 5'd1, 1'b1, 3'd0);
    allocOne("t1", 5'd2, 1'b1, 3'd1);
    allocOne("t1", 5'd3, 1'b0, 3'd2);
    aluWb(3'd2, 32'h33);
    checkOutput("t1 no early commit", 64'(commit_valid), 64'd0);
    aluWb(3'd0, 32'h11);
    checkOutput("t1 wb latency", 64'(commit_valid), 64'd0);
    aluWb(3'd1, 32'h22);
    expectCommit("t1 c0", 1'b1, 5'd1, 32'h11);
    tick();
    expectCommit("t1 c1", 1'b1, 5'd2, 32'h22);
    tick();
    expectCommit("t1 c2", 1'b0, 5'd3, 32'h33);
    tick();
    checkOutput("t1 idle", 64'(commit_valid), 64'd0);

    // Test 2: full buffer refuses allocation until the head retires
    resetDut();
    for (int i = 0; i < 8; i++) allocOne("t2", 5'(i + 8), 1'b1, 3'(i));
    checkOutput("t2 full ready", 64'(alloc_ready), 64'd0);
    alloc_valid    = 1'b1;
    alloc_dest_reg = 5'd30;
    alloc_we       = 1'b1;
    aluWb(3'd0, 32'h2000);
    alloc_valid    = 1'b0;
    checkOutput("t2 still full", 64'(alloc_ready), 64'd0);
    checkOutput("t2 no commit yet", 64'(commit_valid), 64'd0);
    tick();
    expectCommit("t2 c0", 1'b1, 5'd8, 32'h2000);
    checkOutput("t2 ready again", 64'(alloc_ready), 64'd1);
    checkOutput("t2 wrapped id", 64'(alloc_rob_id), 64'd0);

    // Test 3: twenty single-entry round trips, tail wraps 7 -> 0
    resetDut();
    for (int k = 0; k < 20; k++) begin
      allocOne("t3", 5'(k + 1), 1'b1, 3'(k % 8));
      aluWb(3'(k % 8), 32'h1000 + 32'(k));
      tick();
      expectCommit("t3", 1'b1, 5'(k + 1), 32'h1000 + 32'(k));
    end

    // Test 4: exception on id1 after id0 retires; allocation in the
    // exception-detect cycle is discarded by the flush
    resetDut();
    for (int i = 0; i < 4; i++) allocOne("t4", 5'(i + 4), 1'b1, 3'(i));
    applyStimulus(1'b1, 3'd0, 32'h40, 1'b1, 3'd1, 32'h41, 1'b1, 3'd2, 32'h42, ovf);
    aluWb(3'd3, 32'h43);
    expectCommit("t4 c0", 1'b1, 5'd4, 32'h40);
    alloc_valid    = 1'b1;
    alloc_dest_reg = 5'd20;
    alloc_we       = 1'b1;
    tick();
    alloc_valid    = 1'b0;
    checkOutput("t4 flush", 64'(flush), 64'd1);
    checkOutput("t4 xcpt_valid", 64'(xcpt_info.valid), 64'd1);
    checkOutput("t4 xcpt_type", 64'(xcpt_info.xcpt_type), 64'(XCPT_OVERFLOW));
    checkOutput("t4 xcpt_pc", 64'(xcpt_info.pc), 64'h100);
    checkOutput("t4 xcpt_addr", 64'(xcpt_info.addr_val), 64'hDEAD_0000);
    checkOutput("t4 no commit id1", 64'(commit_valid), 64'd0);
    checkOutput("t4 ready in flush", 64'(alloc_ready), 64'd0);
    tick();
    checkOutput("t4 flush drop", 64'(flush), 64'd0);
    checkOutput("t4 xcpt drop", 64'(xcpt_info.valid), 64'd0);
    checkOutput("t4 ready after", 64'(alloc_ready), 64'd1);
    checkOutput("t4 id after", 64'(alloc_rob_id), 64'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t4 no stale commit", 64'(commit_valid), 64'd0);
      tick();
    end

    // Test 5: three ports complete three entries in one cycle
    resetDut();
    allocOne("t5", 5'd8, 1'b1, 3'd0);
    allocOne("t5", 5'd9, 1'b1, 3'd1);
    allocOne("t5", 5'd10, 1'b1, 3'd2);
    applyStimulus(1'b1, 3'd0, 32'hA0, 1'b1, 3'd1, 32'hB1, 1'b1, 3'd2, 32'hC2, '0);
    tick();
    expectCommit("t5 c0", 1'b1, 5'd8, 32'hA0);
    tick();
    expectCommit("t5 c1", 1'b1, 5'd9, 32'hB1);
    tick();
    expectCommit("t5 c2", 1'b1, 5'd10, 32'hC2);

    // Test 6: asynchronous reset while four entries are in flight
    resetDut();
    for (int i = 0; i < 4; i++) allocOne("t6", 5'(i + 1), 1'b1, 3'(i));
    applyStimulus(1'b1, 3'd0, 32'h60, 1'b1, 3'd1, 32'h61, 1'b0, 3'd0, 32'd0, '0);
    tick();
    expectCommit("t6 pre", 1'b1, 5'd1, 32'h60);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6 async commit_valid", 64'(commit_valid), 64'd0);
    checkOutput("t6 async flush", 64'(flush), 64'd0);
    checkOutput("t6 async xcpt_valid", 64'(xcpt_info.valid), 64'd0);
    #2 reset = 1'b0;
    tick();
    checkOutput("t6 id after", 64'(alloc_rob_id), 64'd0);
    checkOutput("t6 ready after", 64'(alloc_ready), 64'd1);
    checkOutput("t6 lost entries", 64'(commit_valid), 64'd0);
    tick();
    checkOutput("t6 lost entries 2", 64'(commit_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer that consumes the per-port writeback results and the reorder_buffer_xcpt_info_t records built by the writeback exception stage.
- Decode allocates one entry per instruction in program order. The ALU, MUL and cache writeback ports complete entries out of order.
- Head entries retire one per cycle to the register file. An exception at the head raises the exception and flushes the pipeline.

Parameters:
- ROB_ENTRIES, 8, number of entries; must be a power of 2.
- ROB_IDX_W, 3, log2(ROB_ENTRIES).
- REG_W, 5, destination register index width.
- DATA_W, 32, result data width.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- alloc_valid  in  1  decode requests an entry.
- alloc_dest_reg  in  REG_W  destination register.
- alloc_we  in  1  instruction writes a register.
- alloc_ready  out  1  entry available; combinational.
- alloc_rob_id  out  ROB_IDX_W  tail index assigned to the current request; combinational.
- alu_wb_valid, mul_wb_valid, cache_wb_valid  in  1 each  writeback strobes.
- alu_wb_rob_id, mul_wb_rob_id, cache_wb_rob_id  in  ROB_IDX_W each  completing entry.
- alu_wb_data, mul_wb_data, cache_wb_data  in  DATA_W each  results.
- alu_rob_xcpt_info, mul_rob_xcpt_info, cache_rob_xcpt_info  in  reorder_buffer_xcpt_info_t each  exception record (valid, xcpt_type, addr_val, pc).
- commit_valid  out  1  one-cycle retire pulse.
- commit_we  out  1  retiring instruction writes the register file.
- commit_dest_reg  out  REG_W  retiring destination register.
- commit_data  out  DATA_W  retiring result.
- xcpt_info  out  reorder_buffer_xcpt_info_t  exception at head; .valid is a one-cycle pulse.
- flush  out  1  one-cycle pipeline flush, coincident with xcpt_info.valid.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - all registered outputs to 0, including xcpt_info fields;
  - head, tail and count to 0;
  - every entry busy/done/xcpt bit;
  - FSM to RUN.
- Storage:
  - Circular array; head and tail wrap modulo ROB_ENTRIES.
  - count is ROB_IDX_W+1 bits.
- alloc_ready = (count < ROB_ENTRIES) & (state == RUN).
  - No allocation when full, even in a commit cycle.
- alloc_rob_id = tail.
- Allocation handshake:
  - On a clock edge with alloc_valid & alloc_ready, entry[tail] gets busy=1, done=0, xcpt=0, dest_reg and we.
  - tail increments.
- Writeback:
  - On an edge with port_wb_valid, entry[id] gets done=1, data stored, and xcpt record stored if xcpt_info.valid.
  - All three ports may write distinct ids in the same cycle.
  - Two ports writing the same id is a protocol violation, flagged by an assertion; priority is cache > mul > alu.
  - Writeback to a non-busy entry is ignored.
- FSM RUN (head entry busy & done evaluated each cycle):
  - No exception at head: at the edge, commit_* regs load the entry, commit_valid=1 for one cycle, entry busy cleared, head++.
  - Exception at head: at the edge, xcpt_info loads the stored record (valid=1), flush=1, state goes to FLUSH, commit_valid=0, and that entry does not retire.
  - Otherwise commit_valid=0.
- FSM FLUSH (exactly one cycle):
  - flush=1 and xcpt_info.valid=1 during this cycle; alloc_ready=0.
  - At the next edge: all entries cleared, head=tail=count=0, flush and xcpt_info.valid drop to 0, state returns to RUN.
- Latency:
  - Writeback in cycle N gives commit_valid in cycle N+2 at the earliest.
  - Back-to-back retirement at 1 per cycle.
- Simultaneous events:
  - count += alloc - commit when allocating and committing in the same cycle.
  - An allocation accepted in the exception-detect cycle is discarded by the flush.
  - Writebacks during FLUSH are ignored.
- Reset mid-operation: outputs go to 0 immediately, without waiting for a clock edge; in-flight entries are lost.

Test Plan:
1. Allocate ids 0,1,2 (dest r1,r2,r3). Write back out of order: id2=0x33, id0=0x11, id1=0x22 on consecutive cycles → commits in consecutive cycles in the order r1/0x11, r2/0x22, r3/0x33.
2. Allocate 8 with no writeback → alloc_ready=0 after the 8th. Write back id0 → commit_valid pulses, then alloc_ready=1 with alloc_rob_id=0.
3. 20 allocate/writeback/commit sequences → alloc_rob_id wraps 7→0. Commit order is preserved and count never exceeds 8.
4. Allocate ids 0-3, all written back; id1 carries overflow with pc=0x100:
   - expected: commit id0;
   - next cycle flush=1 with xcpt_info.valid=1, xcpt_type=overflow, pc=0x100;
   - no commit of ids 1-3;
   - afterwards alloc_rob_id=0 and alloc_ready=1.
5. In one cycle: alu id0, mul id1, cache id2 write back → three consecutive commits with the correct data.
6. Assert reset asynchronously while 4 entries are busy → commit_valid, flush and xcpt_info.valid are 0 before the next edge. After reset release, alloc_rob_id=0.
